// File: rtl/sram_arbiter_ctrl.sv
// Two-port round-robin arbiter and access sequencer for the 64-word SRAM.
// Port A is the MEM-stage data port and port B is the fetch port.
module sram_arbiter_ctrl #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic [31:0] a_rdata,
  output logic        a_done,
  output logic        a_stall,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic [31:0] b_rdata,
  output logic        b_done,
  output logic        b_stall,
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        last_b_q, last_b_d;
  logic        own_b_q, own_b_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;
  logic        grant_a, grant_b;

  // Arbitration, access sequencing and read-data capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_b_d  = last_b_q;
    own_b_d   = own_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie the port that was not served last wins.
        if (a_req && (!b_req || last_b_q)) begin
          grant_a = 1'b1;
        end else if (b_req) begin
          grant_b = 1'b1;
        end
        if (grant_a) begin
          own_b_d = 1'b0;
          we_d    = a_we;
          addr_d  = {a_addr[31:2], 2'b00};
          wdata_d = a_wdata;
        end else if (grant_b) begin
          own_b_d = 1'b1;
          we_d    = b_we;
          addr_d  = {b_addr[31:2], 2'b00};
          wdata_d = b_wdata;
        end
        if (grant_a || grant_b) begin
          cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (own_b_q) b_rdata_d = sram_rdata;
            else         a_rdata_d = sram_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        last_b_d = own_b_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_b_q  <= 1'b1;
      own_b_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_b_q  <= last_b_d;
      own_b_q   <= own_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // Enables and done pulses decode straight from state so reset drops them at once.
  always_comb begin
    sram_r_en  = (state_q == BUSY) && !we_q;
    sram_w_en  = (state_q == BUSY) && we_q;
    sram_addr  = addr_q;
    sram_wdata = wdata_q;
    a_done     = (state_q == DONE) && !own_b_q;
    b_done     = (state_q == DONE) && own_b_q;
    a_rdata    = a_rdata_q;
    b_rdata    = b_rdata_q;
    a_stall    = a_req && !a_done;
    b_stall    = b_req && !b_done;
  end

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Scoreboard bench for sram_arbiter_ctrl with a behavioural 64-word SRAM.
// Stimulus pushes expected completions; a monitor pops them on each done pulse.
module tb_sram_arbiter_ctrl;

  localparam int WAIT = 4;

  logic        clk;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_done, b_done, a_stall, b_stall;
  logic        sram_r_en, sram_w_en;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  logic [31:0] mem [64];
  int          cyc;
  int          n_cmp;
  int          n_bad;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];

  sram_arbiter_ctrl #(.WAIT_CYCLES(WAIT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_done(a_done), .a_stall(a_stall),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_done(b_done), .b_stall(b_stall),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign sram_rdata = mem[sram_addr[7:2]];

  always @(posedge clk) begin
    if (sram_w_en) mem[sram_addr[7:2]] <= sram_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input bit port, input bit we,
                      input logic [31:0] addr, input logic [31:0] rd);
    exp_t e;
    e.port = port;
    e.we = we;
    e.addr = addr;
    e.rdata = rd;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; holds req until done, then drops it after the next edge.
  task automatic do_req(input bit port, input bit we,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat);
    int start;
    int n;
    bit seen;
    start = cyc;
    if (!port) begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      seen = port ? b_done : a_done;
      n++;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout port %0d: got no done expected done", port);
    end
    lat = cyc - start;
    @(posedge clk);
    #1;
    if (!port) a_req = 1'b0;
    else       b_req = 1'b0;
  endtask

  // Monitor: protocol invariants every cycle, scoreboard pop on each done.
  initial begin : monitor
    int          busy_n;
    bit          busy_we;
    logic [31:0] busy_addr;
    exp_t        e;
    busy_n = 0;
    busy_we = 1'b0;
    busy_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_n = 0;
      end else begin
        chk("en_exclusive", {31'b0, sram_r_en & sram_w_en}, 32'd0);
        chk("done_exclusive", {31'b0, a_done & b_done}, 32'd0);
        chk("a_stall", {31'b0, a_stall}, {31'b0, a_req & ~a_done});
        if (sram_r_en || sram_w_en) begin
          if (busy_n > 0) chk("addr_stable", sram_addr, busy_addr);
          busy_addr = sram_addr;
          busy_we = sram_w_en;
          busy_n++;
        end
        if (a_done || b_done) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done a=%0d b=%0d expected none",
                     a_done, b_done);
          end else begin
            e = exp_q.pop_front();
            chk("done_port", {31'b0, b_done}, {31'b0, e.port});
            chk("busy_cycles", busy_n, WAIT);
            chk("busy_addr", busy_addr, e.addr);
            chk("busy_we", {31'b0, busy_we}, {31'b0, e.we});
            if (!e.we) chk("rdata", e.port ? b_rdata : a_rdata, e.rdata);
          end
          busy_n = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l1, l2, l3, l4;
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
    mem[1] = 32'hCAFEF00D;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_r_en", {31'b0, sram_r_en}, 32'd0);
    chk("rst_w_en", {31'b0, sram_w_en}, 32'd0);
    chk("rst_addr", sram_addr, 32'd0);
    chk("rst_wdata", sram_wdata, 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_rdata", b_rdata, 32'd0);
    chk("rst_done", {30'b0, a_done, b_done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: A read of word 4, latency 5
    push(0, 0, 32'h10, 32'hDEADBEEF);
    do_req(0, 0, 32'h10, 32'h0, l1);
    chk("t1_latency", l1, 5);

    // 2: A write then B read back
    push(0, 1, 32'h20, 32'h0);
    do_req(0, 1, 32'h20, 32'h12345678, l1);
    push(1, 0, 32'h20, 32'h12345678);
    do_req(1, 0, 32'h20, 32'h0, l1);
    chk("t2_a_rdata_kept", a_rdata, 32'hDEADBEEF);

    // 3: both held, last served was B -> A,B,A,B
    push(0, 0, 32'h10, 32'hDEADBEEF);
    push(1, 0, 32'h20, 32'h12345678);
    push(0, 0, 32'h20, 32'h12345678);
    push(1, 0, 32'h10, 32'hDEADBEEF);
    fork
      begin
        do_req(0, 0, 32'h10, 32'h0, l1);
        do_req(0, 0, 32'h20, 32'h0, l2);
      end
      begin
        do_req(1, 0, 32'h20, 32'h0, l3);
        do_req(1, 0, 32'h10, 32'h0, l4);
      end
    join
    chk("t3_a_first_lat", l1, 5);
    chk("t3_b_first_lat", l3, 11);

    // 4: unaligned B read aligns to word 1
    push(1, 0, 32'h4, 32'hCAFEF00D);
    do_req(1, 0, 32'h7, 32'h0, l1);

    // 6: A arrives during a B access and waits
    push(1, 0, 32'h10, 32'hDEADBEEF);
    push(0, 0, 32'h4, 32'hCAFEF00D);
    fork
      do_req(1, 0, 32'h10, 32'h0, l1);
      begin
        repeat (2) @(posedge clk);
        #1;
        do_req(0, 0, 32'h4, 32'h0, l2);
      end
      begin
        repeat (2) @(posedge clk);
        #2;
        chk("t6_a_stall", {31'b0, a_stall}, 32'd1);
        chk("t6_b_read", {31'b0, sram_r_en}, 32'd1);
      end
    join

    // 5: reset in second BUSY cycle aborts; next tie goes to A
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("t5_busy_before", {31'b0, sram_r_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_r_en_drop", {31'b0, sram_r_en}, 32'd0);
    chk("t5_done_drop", {30'b0, a_done, b_done}, 32'd0);
    a_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(0, 0, 32'h20, 32'h12345678);
    push(1, 0, 32'h10, 32'hDEADBEEF);
    fork
      do_req(0, 0, 32'h20, 32'h0, l1);
      do_req(1, 0, 32'h10, 32'h0, l2);
    join

    repeat (5) @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
